// File: rtl/pong_pkg.sv
// Shared Pong definitions: FSM state encoding, score width and default win target.
// The display driver imports this package for the score width.
package pong_pkg;

  localparam int unsigned SCORE_W       = 3;
  localparam int unsigned WIN_SCORE_DEF = 5;

  typedef logic [SCORE_W-1:0] score_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  // Saturating increment: a score never exceeds the win target and never wraps.
  function automatic score_t score_inc(input score_t s, input score_t lim);
    return (s >= lim) ? lim : score_t'(s + score_t'(1));
  endfunction

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector: one registered copy of the level input.
// A held-high level produces a single one-cycle pulse.
module edge_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic i_level,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_level;
    end
  end

  assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/score_keeper.sv
// Pong score keeper: serve countdown, goal scoring, win detection and restart.
// All outputs come straight from registers.
module score_keeper
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE    = WIN_SCORE_DEF,
  parameter int unsigned SERVE_CYCLES = 50_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               player_goal,
  input  logic               cpu_goal,
  input  logic               new_game,
  output logic [SCORE_W-1:0] player_score,
  output logic [SCORE_W-1:0] cpu_score,
  output logic               serve_hold,
  output logic               serve_dir,
  output logic               game_over,
  output logic               winner
);

  localparam int unsigned      CNT_W    = (SERVE_CYCLES > 1) ? $clog2(SERVE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SERVE_CYCLES - 1);
  localparam score_t           WIN      = score_t'(WIN_SCORE);

  logic w_pg_rise;
  logic w_cg_rise;
  logic w_ng_rise;

  edge_rise u_pg_edge (.clk(clk), .rst_n(rst_n), .i_level(player_goal), .o_rise(w_pg_rise));
  edge_rise u_cg_edge (.clk(clk), .rst_n(rst_n), .i_level(cpu_goal),    .o_rise(w_cg_rise));
  edge_rise u_ng_edge (.clk(clk), .rst_n(rst_n), .i_level(new_game),    .o_rise(w_ng_rise));

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  score_t           r_pscore;
  score_t           r_cscore;
  score_t           w_pscore_next;
  score_t           w_cscore_next;
  score_t           w_pscore_inc;
  score_t           w_cscore_inc;
  logic             r_dir;
  logic             w_dir_next;
  logic             r_winner;
  logic             w_winner_next;
  logic             r_hold;
  logic             r_over;
  logic             w_single_goal;

  assign w_pscore_inc  = score_inc(r_pscore, WIN);
  assign w_cscore_inc  = score_inc(r_cscore, WIN);
  assign w_single_goal = (r_state == ST_PLAY) && (w_pg_rise ^ w_cg_rise);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_ng_rise) w_next = ST_SERVE;
      end
      ST_SERVE: begin
        if (w_ng_rise)        w_next = ST_SERVE;
        else if (r_cnt == '0) w_next = ST_PLAY;
      end
      ST_PLAY: begin
        // new_game outranks goals; simultaneous goals just re-serve
        if (w_ng_rise)                   w_next = ST_SERVE;
        else if (w_pg_rise && w_cg_rise) w_next = ST_SERVE;
        else if (w_pg_rise)              w_next = (w_pscore_inc == WIN) ? ST_OVER : ST_SERVE;
        else if (w_cg_rise)              w_next = (w_cscore_inc == WIN) ? ST_OVER : ST_SERVE;
      end
      ST_OVER: begin
        if (w_ng_rise) w_next = ST_SERVE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_next    = r_cnt;
    w_pscore_next = r_pscore;
    w_cscore_next = r_cscore;
    w_dir_next    = r_dir;
    w_winner_next = r_winner;

    // The countdown reloads on every entry into SERVE, including a restart from within SERVE.
    if ((w_next == ST_SERVE) && ((r_state != ST_SERVE) || w_ng_rise)) begin
      w_cnt_next = CNT_LOAD;
    end else if ((r_state == ST_SERVE) && (r_cnt != '0)) begin
      w_cnt_next = r_cnt - CNT_W'(1);
    end

    if (w_ng_rise) begin
      w_pscore_next = '0;
      w_cscore_next = '0;
      w_dir_next    = 1'b1;
    end else if (w_single_goal && w_pg_rise) begin
      w_pscore_next = w_pscore_inc;
      w_dir_next    = 1'b1;
      if (w_pscore_inc == WIN) w_winner_next = 1'b0;
    end else if (w_single_goal && w_cg_rise) begin
      w_cscore_next = w_cscore_inc;
      w_dir_next    = 1'b0;
      if (w_cscore_inc == WIN) w_winner_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_pscore <= '0;
      r_cscore <= '0;
      r_dir    <= 1'b1;
      r_winner <= 1'b0;
      r_hold   <= 1'b1;
      r_over   <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_next;
      r_pscore <= w_pscore_next;
      r_cscore <= w_cscore_next;
      r_dir    <= w_dir_next;
      r_winner <= w_winner_next;
      r_hold   <= (w_next != ST_PLAY);
      r_over   <= (w_next == ST_OVER);
    end
  end

  assign player_score = r_pscore;
  assign cpu_score    = r_cscore;
  assign serve_hold   = r_hold;
  assign serve_dir    = r_dir;
  assign game_over    = r_over;
  assign winner       = r_winner;

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 The block SHALL have parameter WIN_SCORE, default 5, meaning the points needed to win; legal range 1..7.
REQ-002 The block SHALL have parameter SERVE_CYCLES, default 50_000_000, meaning the clk cycles the ball is held before each serve; minimum 1.
REQ-003 The block SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port player_goal  input  1  level from ball logic; high while the ball is past the CPU paddle line.
REQ-006 The block SHALL have port cpu_goal  input  1  level from ball logic; high while the ball is past the player paddle line.
REQ-007 The block SHALL have port new_game  input  1  synchronised, debounced start button level.
REQ-008 The block SHALL have port player_score  output  3  player points, unsigned.
REQ-009 The block SHALL have port cpu_score  output  3  CPU points, unsigned.
REQ-010 The block SHALL have port serve_hold  output  1  high means ball and paddles are frozen at centre.
REQ-011 The block SHALL have port serve_dir  output  1  0 = serve toward player, 1 = serve toward CPU.
REQ-012 The block SHALL have port game_over  output  1  high while a winner is declared.
REQ-013 The block SHALL have port winner  output  1  0 = player, 1 = CPU; meaningful only while game_over is high.

Function
REQ-014 The block SHALL implement states IDLE, SERVE, PLAY and OVER.
REQ-015 The block SHALL detect rising edges of player_goal, cpu_goal and new_game using one registered copy of each input; a held level SHALL count once.
REQ-016 IDLE SHALL hold serve_hold=1, both scores at 0 and game_over=0; a new_game edge SHALL go to SERVE with serve_dir=1.
REQ-017 SERVE SHALL load a down-counter with SERVE_CYCLES-1 on entry, hold serve_hold=1, and go to PLAY in the cycle after the counter reads 0, so serve_hold is high for exactly SERVE_CYCLES cycles.
REQ-018 In PLAY, serve_hold SHALL be 0.
REQ-019 In PLAY, a player_goal edge SHALL increment player_score in the next cycle and set serve_dir=1; a cpu_goal edge SHALL increment cpu_score and set serve_dir=0.
REQ-020 If both goal edges occur in the same cycle, neither score SHALL change, serve_dir SHALL be kept, and the state SHALL go to SERVE.
REQ-021 After a scoring increment, if the new score equals WIN_SCORE the state SHALL go to OVER with winner set to the scoring side; otherwise it SHALL go to SERVE.
REQ-022 Goal edges in IDLE, SERVE or OVER SHALL be ignored.
REQ-023 Scores SHALL never exceed WIN_SCORE and SHALL never wrap.
REQ-024 OVER SHALL hold game_over=1, serve_hold=1 and freeze both scores.
REQ-025 A new_game edge in OVER SHALL clear both scores and game_over and go to SERVE with serve_dir=1.
REQ-026 A new_game edge in SERVE or PLAY SHALL restart the game: scores cleared, SERVE entered and the counter reloaded.
REQ-027 A new_game edge SHALL take priority over goal edges in the same cycle.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 When rst_n=0, the block SHALL immediately enter IDLE with player_score=0, cpu_score=0, serve_hold=1, serve_dir=1, game_over=0, winner=0, the serve counter at 0 and the edge-detect registers at 0.
REQ-030 Reset asserted mid-serve or mid-game SHALL abort the game with no pending score update.
REQ-031 After reset release, IDLE SHALL be left only by a new_game rising edge.

Structure
REQ-032 The state encoding, the 3-bit score width and the WIN_SCORE default SHALL live in shared package pong_pkg, which the display driver also uses for score width.
REQ-033 Edge detection SHALL be one reusable sub-module, edge_rise, instantiated three times; the remaining logic SHALL be flat.

Verification (WIN_SCORE=3, SERVE_CYCLES=4)
REQ-034 A bench SHALL check reset then a new_game pulse -> serve_hold high for exactly 4 cycles, then 0, with scores 0/0.
REQ-035 A bench SHALL check player_goal held high for 10 cycles in PLAY -> player_score=1 only, serve_dir=1 and serve_hold high 4 cycles.
REQ-036 A bench SHALL check three cpu_goal edges -> cpu_score=3, game_over=1, winner=1, and a further cpu_goal leaving cpu_score at 3.
REQ-037 A bench SHALL check player_goal and cpu_goal rising in the same cycle -> scores unchanged and the state returning to SERVE.
REQ-038 A bench SHALL check new_game in OVER -> scores 0/0, game_over=0, serve_dir=1 and the serve countdown restarted.
REQ-039 A bench SHALL check rst_n pulsed low mid-PLAY at score 2/1 -> outputs at reset values immediately, without waiting for a clk edge.
